// File: rtl/a23_gc_pkg.sv
// Shared types and constants for the a23 garbled-circuit run controller.
package a23_gc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [1:0] SEL_CODE = 2'd0;
  localparam logic [1:0] SEL_G    = 2'd1;
  localparam logic [1:0] SEL_E    = 2'd2;
  localparam logic [1:0] SEL_BAD  = 2'd3;

  localparam int DEF_CODE_MEM = 512;
  localparam int DEF_G_MEM    = 64;
  localparam int DEF_E_MEM    = 64;
  localparam int DEF_OUT_MEM  = 64;

  function automatic logic is_load_st(state_e s);
    return (s == ST_IDLE) || (s == ST_LOAD) ||
           (s == ST_DONE);
  endfunction

endpackage

// File: rtl/a23_gc_img_loader.sv
// One flat init image plus its word index; words past the end are
// dropped and flagged.
module a23_gc_img_loader #(
  parameter int N = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          clr,
  input  logic          last,
  input  logic [31:0]   data,
  output logic [N*32-1:0] img,
  output logic          ovf
);

  localparam int IW = $clog2(N + 1);

  logic [IW-1:0]   idx_q, idx_d;
  logic [N*32-1:0] img_q, img_d;

  assign ovf = we && (idx_q >= IW'(N));
  assign img = img_q;

  always_comb begin
    img_d = img_q;
    idx_d = idx_q;
    if (we) begin
      if (!ovf) begin
        img_d[32*int'(idx_q) +: 32] = data;
        idx_d = idx_q + IW'(1);
      end
      if (last) idx_d = '0;
    end else if (clr) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      img_q <= '0;
    end else begin
      idx_q <= idx_d;
      img_q <= img_d;
    end
  end

endmodule

// File: rtl/a23_gc_run_ctrl.sv
// Loads core images from a word stream, runs the core to terminate or
// timeout, then streams the captured output image.
module a23_gc_run_ctrl
  import a23_gc_pkg::*;
#(
  parameter int CODE_MEM_SIZE = DEF_CODE_MEM,
  parameter int G_MEM_SIZE    = DEF_G_MEM,
  parameter int E_MEM_SIZE    = DEF_E_MEM,
  parameter int OUT_MEM_SIZE  = DEF_OUT_MEM,
  parameter int CC_W          = 32,
  parameter int MAX_CC        = 1048576
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_sel,
  input  logic [31:0]                in_data,
  input  logic                       in_last,
  input  logic                       start,
  output logic                       core_rst,
  output logic [CODE_MEM_SIZE*32-1:0] p_init,
  output logic [G_MEM_SIZE*32-1:0]   g_init,
  output logic [E_MEM_SIZE*32-1:0]   e_init,
  input  logic [OUT_MEM_SIZE*32-1:0] o,
  input  logic                       terminate,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic                       load_err,
  output logic [CC_W-1:0]            cc
);

  localparam int RW = $clog2(OUT_MEM_SIZE);

  state_e                    state_q, state_d;
  logic [CC_W-1:0]           cc_q, cc_d;
  logic [RW-1:0]             ridx_q, ridx_d;
  logic [OUT_MEM_SIZE*32-1:0] snap_q, snap_d;
  logic tmo_q, tmo_d, done_q, done_d, err_q, err_d;
  logic rdy_q, crst_q;
  logic acc, ovf_p, ovf_g, ovf_e;

  assign in_ready = rdy_q && !start;
  assign acc      = in_valid && in_ready;

  a23_gc_img_loader #(.N(CODE_MEM_SIZE)) u_code (
    .clk(clk), .rst(rst),
    .we(acc && in_sel == SEL_CODE),
    .clr(acc && in_sel != SEL_CODE),
    .last(in_last), .data(in_data),
    .img(p_init), .ovf(ovf_p)
  );

  a23_gc_img_loader #(.N(G_MEM_SIZE)) u_g (
    .clk(clk), .rst(rst),
    .we(acc && in_sel == SEL_G),
    .clr(acc && in_sel != SEL_G),
    .last(in_last), .data(in_data),
    .img(g_init), .ovf(ovf_g)
  );

  a23_gc_img_loader #(.N(E_MEM_SIZE)) u_e (
    .clk(clk), .rst(rst),
    .we(acc && in_sel == SEL_E),
    .clr(acc && in_sel != SEL_E),
    .last(in_last), .data(in_data),
    .img(e_init), .ovf(ovf_e)
  );

  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    ridx_d  = ridx_q;
    snap_d  = snap_q;
    tmo_d   = tmo_q;
    done_d  = done_q;
    err_d   = err_q || ovf_p || ovf_g || ovf_e ||
              (acc && in_sel == SEL_BAD);
    unique case (state_q)
      ST_IDLE, ST_LOAD, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          cc_d    = '0;
          tmo_d   = 1'b0;
          done_d  = 1'b0;
          ridx_d  = '0;
        end else if (acc) begin
          state_d = ST_LOAD;
          done_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // terminate is checked first so it wins over the limit
        if (terminate) begin
          snap_d  = o;
          state_d = ST_DRAIN;
        end else begin
          cc_d = cc_q + CC_W'(1);
          if (cc_d == CC_W'(MAX_CC)) begin
            snap_d  = o;
            tmo_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (ridx_q == RW'(OUT_MEM_SIZE - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            ridx_d = ridx_q + RW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cc_q    <= '0;
      ridx_q  <= '0;
      snap_q  <= '0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      crst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      ridx_q  <= ridx_d;
      snap_q  <= snap_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= is_load_st(state_d);
      crst_q  <= (state_d != ST_RUN);
    end
  end

  assign core_rst  = crst_q;
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = snap_q[32*int'(ridx_q) +: 32];
  assign out_last  = out_valid &&
                     (ridx_q == RW'(OUT_MEM_SIZE - 1));
  assign busy      = (state_q == ST_RUN) ||
                     (state_q == ST_DRAIN);
  assign done      = done_q;
  assign timeout   = tmo_q;
  assign load_err  = err_q;
  assign cc        = cc_q;

endmodule

// File: doc/a23_gc_run_ctrl.md
Name: a23_gc_run_ctrl

Overview:
Run controller wrapping the garbled-circuit ARM core (a23_gc_main) for the synthesis/emulation flow. Fills the code, G (Alice) and E (Bob) init images from a 32-bit word stream, releases core reset, and counts cycles until terminate or a programmable timeout. It then snapshots the flat output image and streams it out word by word. This replaces file-based memory preload with a reusable handshake front end.

Parameters:
CODE_MEM_SIZE, 512, code image words (maps 0x00000000)
G_MEM_SIZE, 64, Alice input words
E_MEM_SIZE, 64, Bob input words
OUT_MEM_SIZE, 64, output image words
CC_W, 32, cycle counter width
MAX_CC, 1048576, timeout cycle limit (must fit in CC_W bits)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  load word valid
in_ready  out  1  load word accepted when in_valid&in_ready
in_sel  in  2  target region: 0 code, 1 G, 2 E, 3 illegal
in_data  in  32  load word
in_last  in  1  last word of current region; next word restarts at index 0
start  in  1  one-cycle pulse: begin run
core_rst  out  1  active-high reset to core
p_init  out  CODE_MEM_SIZE*32  code image, word i at [32i+31:32i]
g_init  out  G_MEM_SIZE*32  Alice image
e_init  out  E_MEM_SIZE*32  Bob image
o  in  OUT_MEM_SIZE*32  core output image
terminate  in  1  core finished
out_valid  out  1  output word valid
out_ready  in  1  sink accepts
out_data  out  32  output word, index 0 first
out_last  out  1  marks word OUT_MEM_SIZE-1
busy  out  1  state is RUN or DRAIN
done  out  1  run complete, all words drained
timeout  out  1  run ended by MAX_CC
load_err  out  1  sticky: overflow or in_sel==3
cc  out  CC_W  cycles counted in last/current run

Behaviour:
- Reset (rst low, async): state IDLE; all images, snapshot, counters zero; core_rst=1; in_ready=0; out_valid=0; busy=done=timeout=load_err=0; cc=0.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE/LOAD/DONE: in_ready=1, core_rst=1. Accepted word goes to region in_sel at word index idx, then idx++. in_last or a change of in_sel resets idx to 0 after the write. Any accepted word moves state to LOAD; done clears.
- Overflow (idx ≥ region size) or in_sel==3: word dropped, load_err=1 (sticky until rst). Unwritten words retain prior value.
- start in IDLE/LOAD/DONE -> RUN on the next edge. cc, timeout and done clear; in_ready=0. start is ignored in RUN/DRAIN, and an in_valid word arriving the same cycle as start is not accepted.
- RUN: core_rst=0 from the first RUN cycle. cc increments on every RUN edge where terminate=0, so cc equals the count of released core cycles before terminate is sampled.
- terminate=1 in RUN: snapshot o (all words) that edge -> DRAIN, core_rst=1 from the next cycle.
- cc reaching MAX_CC with terminate=0: snapshot o, timeout=1 -> DRAIN. If terminate and the limit coincide, terminate wins and timeout=0.
- DRAIN: out_data = snapshot[ridx], out_valid=1, out_last=(ridx==OUT_MEM_SIZE-1). ridx advances only on out_valid&out_ready. out_data is stable while stalled. After the last handshake: DONE, done=1, out_valid=0.
- DONE: images are preserved; a new start re-runs the same program; new words begin a fresh load.
- rst mid-RUN/DRAIN aborts immediately to IDLE with all state cleared; the core is held in reset.

Decomposition:
- Package a23_gc_pkg: state encoding, region select constants (SEL_CODE=0, SEL_G=1, SEL_E=2), default memory sizes.
- One sub-module a23_gc_img_loader, instantiated 3×: parametrised by word count; holds one flat image and its idx counter; reports overflow.
- FSM, cycle counter and drain logic live in the top.

Test Plan:
- Load code words 0..3 = 0xE3A00001,0xE3A01002,0xE0802001,0xEAFFFFFE (in_last on 4th); G[0]=0x11111111; E[0]=0x22222222 -> p_init[127:0], g_init[31:0], e_init[31:0] match; load_err=0.
- start, stub asserts terminate after 37 released cycles with o word k = k*3 -> cc=37, timeout=0, 64 words out 0,3,...,189, out_last only on word 63, then done=1.
- MAX_CC=100, terminate never asserted -> cc=100, timeout=1, drain of snapshot completes, done=1.
- Toggle out_ready 1/0 every cycle during DRAIN -> no lost or duplicated words; out_data held during stalls.
- 65 words to G with G_MEM_SIZE=64 -> 65th dropped, load_err=1; word 3 with in_sel=3 -> dropped, load_err stays 1.
- rst low mid-RUN at cc=20 -> outputs reach reset values asynchronously, core_rst=1, images zero; re-load and run completes normally.
